// File: rtl/reg_campo_tiempo_pkg.sv
// +----------------------------------------------------------------------+
// | reg_campo_tiempo_pkg                                                 |
// | Shared converter state encoding and BCD digit constants.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package reg_campo_tiempo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CARGA = 2'd1,
    DESPL = 2'd2
  } conv_state_e;

  localparam logic [3:0] c_DIGIT_MAX   = 4'd9;
  localparam logic [3:0] c_ADD3_THRESH = 4'd5;

endpackage

`default_nettype wire

// File: rtl/reg_campo_tiempo_bin2bcd_serial.sv
// +----------------------------------------------------------------------+
// | bin2bcd_serial                                                       |
// | Serial double-dabble binary-to-BCD converter, one bit per cycle.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bin2bcd_serial
  import reg_campo_tiempo_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int BCD_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int c_BCD_W = 4 * BCD_DIGITS;
  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  conv_state_e          state_q;
  logic [c_BCD_W-1:0]   scratch_q;
  logic [c_BCD_W-1:0]   bcd_q;
  logic [WIDTH-1:0]     shift_q;
  logic [c_CNT_W-1:0]   cnt_q;
  logic                 done_q;
  logic [c_BCD_W-1:0]   w_adj;
  logic [c_BCD_W-1:0]   w_scratch_sh;

  generate
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
      assign w_adj[4*g +: 4] = (scratch_q[4*g +: 4] >= c_ADD3_THRESH)
                             ? scratch_q[4*g +: 4] + 4'd3
                             : scratch_q[4*g +: 4];
    end
  endgenerate

  assign w_scratch_sh = {w_adj[c_BCD_W-2:0], shift_q[WIDTH-1]};

  // A start at any point restarts from CARGA, so only the newest value is published.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CARGA;
      scratch_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else if (start) begin
      state_q <= CARGA;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        CARGA: begin
          shift_q   <= bin;
          scratch_q <= '0;
          cnt_q     <= '0;
          state_q   <= DESPL;
        end
        DESPL: begin
          scratch_q <= w_scratch_sh;
          shift_q   <= shift_q << 1;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == c_CNT_LAST) begin
            bcd_q   <= w_scratch_sh;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

`default_nettype wire

// File: rtl/reg_campo_tiempo.sv
// +----------------------------------------------------------------------+
// | reg_campo_tiempo                                                     |
// | Wrapping time-field register with BCD load and serial BCD readout.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_campo_tiempo
  import reg_campo_tiempo_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 59,
  parameter int BCD_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    EN,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    load,
  input  logic [4*BCD_DIGITS-1:0] load_bcd,
  output logic [WIDTH-1:0]        bin_out,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    valid_out,
  output logic                    carry_out,
  output logic                    borrow_out,
  output logic                    load_err
);

  localparam int c_BCD_W = 4 * BCD_DIGITS;
  localparam logic [WIDTH-1:0] c_MIN = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0]   val_q, val_d;
  logic               carry_q, carry_d;
  logic               borrow_q, borrow_d;
  logic               err_q, err_d;
  logic               w_update;
  logic               w_digits_ok;
  logic               w_load_ok;
  logic [31:0]        w_load_bin;
  logic               w_busy;
  logic               w_done;
  logic [c_BCD_W-1:0] w_bcd;

  // Returns {all digits legal, binary value}.
  function automatic logic [32:0] decode_bcd(input logic [c_BCD_W-1:0] b);
    logic        ok;
    logic [31:0] acc;
    logic [31:0] weight;
    ok     = 1'b1;
    acc    = '0;
    weight = 32'd1;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (b[4*k +: 4] > c_DIGIT_MAX) ok = 1'b0;
      acc    = acc + weight * 32'(b[4*k +: 4]);
      weight = weight * 32'd10;
    end
    return {ok, acc};
  endfunction

  assign {w_digits_ok, w_load_bin} = decode_bcd(load_bcd);
  assign w_load_ok = w_digits_ok
                  && (w_load_bin >= 32'(MIN_VAL))
                  && (w_load_bin <= 32'(MAX_VAL));

  always_comb begin
    val_d    = val_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    w_update = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        val_d    = w_load_bin[WIDTH-1:0];
        w_update = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (inc && !dec) begin
      w_update = 1'b1;
      if (val_q == c_MAX) begin
        val_d   = c_MIN;
        carry_d = 1'b1;
      end else begin
        val_d = val_q + 1'b1;
      end
    end else if (dec && !inc) begin
      w_update = 1'b1;
      if (val_q == c_MIN) begin
        val_d    = c_MAX;
        borrow_d = 1'b1;
      end else begin
        val_d = val_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q    <= c_MIN;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      val_q    <= val_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  bin2bcd_serial #(
    .WIDTH      (WIDTH),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_update),
    .bin   (val_q),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  assign valid_out  = w_done && !w_busy;
  assign bcd_out    = (EN && valid_out) ? w_bcd : '0;
  assign bin_out    = val_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign load_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_campo_tiempo.sv
// +----------------------------------------------------------------------+
// | tb_reg_campo_tiempo                                                  |
// | Scoreboard bench: two field configurations (0..59 and 1..31).        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_campo_tiempo;

  localparam int c_WIDTH = 6;

  logic       clk;
  logic       rst;
  logic       en;
  logic       inc;
  logic       dec;
  logic       load;
  logic [7:0] load_bcd;

  logic [5:0] bin_o    [2];
  logic [7:0] bcd_o    [2];
  logic       valid_o  [2];
  logic       carry_o  [2];
  logic       borrow_o [2];
  logic       err_o    [2];

  int minv[2] = '{0, 1};
  int maxv[2] = '{59, 31};

  int m_val    [2];
  int m_pend   [2];
  bit m_valid  [2];
  bit m_carry  [2];
  bit m_borrow [2];
  bit m_err    [2];
  bit pv       [2];
  int q0[$];
  int q1[$];

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  reg_campo_tiempo u_dut0 (
    .clk        (clk),
    .reset      (rst),
    .EN         (en),
    .inc        (inc),
    .dec        (dec),
    .load       (load),
    .load_bcd   (load_bcd),
    .bin_out    (bin_o[0]),
    .bcd_out    (bcd_o[0]),
    .valid_out  (valid_o[0]),
    .carry_out  (carry_o[0]),
    .borrow_out (borrow_o[0]),
    .load_err   (err_o[0])
  );

  reg_campo_tiempo #(
    .WIDTH      (6),
    .MIN_VAL    (1),
    .MAX_VAL    (31),
    .BCD_DIGITS (2)
  ) u_dut1 (
    .clk        (clk),
    .reset      (rst),
    .EN         (en),
    .inc        (inc),
    .dec        (dec),
    .load       (load),
    .load_bcd   (load_bcd),
    .bin_out    (bin_o[1]),
    .bcd_out    (bcd_o[1]),
    .valid_out  (valid_o[1]),
    .carry_out  (carry_o[1]),
    .borrow_out (borrow_o[1]),
    .load_err   (err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[dut%0d] got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Reference model: field value plus a countdown to the moment the readout publishes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_val[i]    = minv[i];
        m_pend[i]   = c_WIDTH + 1;
        m_valid[i]  = 1'b0;
        m_carry[i]  = 1'b0;
        m_borrow[i] = 1'b0;
        m_err[i]    = 1'b0;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit upd;
        int v;
        bit ok;
        upd         = 1'b0;
        m_carry[i]  = 1'b0;
        m_borrow[i] = 1'b0;
        m_err[i]    = 1'b0;
        if (load) begin
          v  = 10 * int'(load_bcd[7:4]) + int'(load_bcd[3:0]);
          ok = (load_bcd[7:4] <= 4'd9) && (load_bcd[3:0] <= 4'd9) && (v >= minv[i]) && (v <= maxv[i]);
          if (ok) begin
            m_val[i] = v;
            upd      = 1'b1;
          end else begin
            m_err[i] = 1'b1;
          end
        end else if (inc && !dec) begin
          upd = 1'b1;
          if (m_val[i] == maxv[i]) begin
            m_val[i]   = minv[i];
            m_carry[i] = 1'b1;
          end else begin
            m_val[i] = m_val[i] + 1;
          end
        end else if (dec && !inc) begin
          upd = 1'b1;
          if (m_val[i] == minv[i]) begin
            m_val[i]    = maxv[i];
            m_borrow[i] = 1'b1;
          end else begin
            m_val[i] = m_val[i] - 1;
          end
        end
        if (upd) begin
          m_pend[i]  = c_WIDTH + 1;
          m_valid[i] = 1'b0;
        end else if (m_pend[i] > 0) begin
          m_pend[i] = m_pend[i] - 1;
          if (m_pend[i] == 0) begin
            m_valid[i] = 1'b1;
            if (i == 0) q0.push_back(to_bcd(m_val[i]));
            else        q1.push_back(to_bcd(m_val[i]));
          end
        end
      end
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on each publish.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        bit have;
        int expq;
        have = 1'b0;
        expq = 0;
        if (i == 0) begin
          if (q0.size() > 0) begin have = 1'b1; expq = q0.pop_front(); end
        end else begin
          if (q1.size() > 0) begin have = 1'b1; expq = q1.pop_front(); end
        end
        chk("bin_out", i, int'(bin_o[i]), m_val[i]);
        chk("valid_out", i, int'(valid_o[i]), int'(m_valid[i]));
        chk("carry_out", i, int'(carry_o[i]), int'(m_carry[i]));
        chk("borrow_out", i, int'(borrow_o[i]), int'(m_borrow[i]));
        chk("load_err", i, int'(err_o[i]), int'(m_err[i]));
        chk("bcd_out", i, int'(bcd_o[i]), (en && m_valid[i]) ? to_bcd(m_val[i]) : 0);
        if (valid_o[i] && !pv[i]) begin
          if (!have) chk("sb_unexpected_publish", i, 1, 0);
          else       chk("sb_publish_bcd", i, int'(bcd_o[i]), en ? expq : 0);
        end else if (have) begin
          chk("sb_missing_publish", i, 0, 1);
        end
        pv[i] = valid_o[i];
      end
    end
  end

  task automatic cyc(input bit l, input logic [7:0] b, input bit up, input bit dn, input bit e);
    @(posedge clk);
    #1;
    load     = l;
    load_bcd = b;
    inc      = up;
    dec      = dn;
    en       = e;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    inc      = 1'b0;
    dec      = 1'b0;
    load     = 1'b0;
    load_bcd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_on = 1'b1;
    idle(10);

    cyc(1'b1, 8'h58, 1'b0, 1'b0, 1'b1); idle(8);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); idle(9);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1); idle(9);

    cyc(1'b1, 8'h31, 1'b0, 1'b0, 1'b1); idle(8);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h32, 1'b0, 1'b0, 1'b1); idle(3);
    cyc(1'b1, 8'h1A, 1'b0, 1'b0, 1'b1); idle(3);
    cyc(1'b1, 8'h45, 1'b1, 1'b0, 1'b1); idle(9);

    cyc(1'b1, 8'h10, 1'b0, 1'b0, 1'b1); idle(8);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(10);

    repeat (5) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (9) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(2);

    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_rst_bin", i, int'(bin_o[i]), minv[i]);
      chk("async_rst_valid", i, int'(valid_o[i]), 0);
      chk("async_rst_bcd", i, int'(bcd_o[i]), 0);
      chk("async_rst_pulses", i, int'({carry_o[i], borrow_o[i], err_o[i]}), 0);
    end
    inc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(9);

    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
      else                           b = 8'(to_bcd(int'($urandom_range(0, 63))));
      if ($urandom_range(0, 19) == 0) idle(9);
      else cyc(r < 2, b, (r >= 2 && r < 6) || r == 9, (r >= 6 && r < 9) || r == 9, $urandom_range(0, 7) != 0);
    end
    idle(12);
    chk("sb_leftover", 0, q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
